axi_burst_master: RTL and testbench

//  AXI4 burst master feeding one master port (mN_*) of AXI_Interconnect.

---
 rtl/axi_burst_master.sv | 239 +++++++++++++++++++++++
 tb/tb_axi_burst_master.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 INCR burst master: one command becomes one AW/W/B or AR/R burst,
// with 4KB boundary rejection and response/ID/last-beat checking reported on done/resp_err.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// CHK   | latched command, checking the 4KB boundary
// ERR   | burst would cross 4KB, done+resp_err pulse, no AXI traffic
// AW    | AWVALID held until AWREADY
// W     | streaming write beats from wr_* to W channel
// B     | waiting for write response
// AR    | ARVALID held until ARREADY
// R     | streaming read beats from R channel to rd_*
module axi_burst_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int USER_WIDTH = 1,
    parameter int MASTER_ID  = 0
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,

    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [7:0]                cmd_len,

    input  logic [DATA_WIDTH-1:0]     wr_data,
    input  logic                      wr_valid,
    output logic                      wr_ready,

    output logic [DATA_WIDTH-1:0]     rd_data,
    output logic                      rd_last,
    output logic                      rd_valid,
    input  logic                      rd_ready,

    output logic                      done,
    output logic                      resp_err,

    output logic [ID_WIDTH-1:0]       AWID,
    output logic [ADDR_WIDTH-1:0]     AWADDR,
    output logic [7:0]                AWLEN,
    output logic [2:0]                AWSIZE,
    output logic [1:0]                AWBURST,
    output logic                      AWLOCK,
    output logic [3:0]                AWCACHE,
    output logic [2:0]                AWPROT,
    output logic [3:0]                AWQOS,
    output logic [3:0]                AWREGION,
    output logic [USER_WIDTH-1:0]     AWUSER,
    output logic                      AWVALID,
    input  logic                      AWREADY,

    output logic [DATA_WIDTH-1:0]     WDATA,
    output logic [DATA_WIDTH/8-1:0]   WSTRB,
    output logic                      WLAST,
    output logic [USER_WIDTH-1:0]     WUSER,
    output logic                      WVALID,
    input  logic                      WREADY,

    input  logic [ID_WIDTH-1:0]       BID,
    input  logic [1:0]                BRESP,
    input  logic                      BVALID,
    output logic                      BREADY,

    output logic [ID_WIDTH-1:0]       ARID,
    output logic [ADDR_WIDTH-1:0]     ARADDR,
    output logic [7:0]                ARLEN,
    output logic [2:0]                ARSIZE,
    output logic [1:0]                ARBURST,
    output logic                      ARLOCK,
    output logic [3:0]                ARCACHE,
    output logic [2:0]                ARPROT,
    output logic [3:0]                ARQOS,
    output logic [3:0]                ARREGION,
    output logic [USER_WIDTH-1:0]     ARUSER,
    output logic                      ARVALID,
    input  logic                      ARREADY,

    input  logic [ID_WIDTH-1:0]       RID,
    input  logic [DATA_WIDTH-1:0]     RDATA,
    input  logic [1:0]                RRESP,
    input  logic                      RLAST,
    input  logic                      RVALID,
    output logic                      RREADY
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int SIZE       = $clog2(STRB_WIDTH);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CHK  = 3'd1;
    localparam logic [2:0] S_ERR  = 3'd2;
    localparam logic [2:0] S_AW   = 3'd3;
    localparam logic [2:0] S_W    = 3'd4;
    localparam logic [2:0] S_B    = 3'd5;
    localparam logic [2:0] S_AR   = 3'd6;
    localparam logic [2:0] S_R    = 3'd7;

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic                  write_q;
    logic [7:0]            beat;
    logic [7:0]            beat_inc;
    logic                  err_sticky;
    logic [23:0]           burst_end;
    logic                  cross_4k;
    logic                  w_fire;
    logic                  r_fire;
    logic                  last_beat;
    logic                  r_beat_err;
    logic                  b_err;

    // Offset in page plus burst byte count; anything past 4096 spills into the next page.
    assign burst_end  = 24'(addr_q[11:0]) + (24'(len_q) + 24'd1) * 24'(STRB_WIDTH);
    assign cross_4k   = burst_end > 24'd4096;

    assign last_beat  = (beat == len_q);
    assign beat_inc   = (beat == 8'hFF) ? beat : beat + 8'd1;
    assign w_fire     = WVALID && WREADY;
    assign r_fire     = RVALID && RREADY;
    assign r_beat_err = (RRESP != 2'b00) || (RID != ID_WIDTH'(MASTER_ID)) || (RLAST != last_beat);
    assign b_err      = (BRESP != 2'b00) || (BID != ID_WIDTH'(MASTER_ID));

    // Gated with the reset pin so the command port is closed while held in reset.
    assign cmd_ready  = (state == S_IDLE) && ARESETn;

    assign AWID       = ID_WIDTH'(MASTER_ID);
    assign AWADDR     = addr_q;
    assign AWLEN      = len_q;
    assign AWSIZE     = 3'(SIZE);
    assign AWBURST    = 2'b01;
    assign AWLOCK     = 1'b0;
    assign AWCACHE    = 4'b0000;
    assign AWPROT     = 3'b000;
    assign AWQOS      = 4'b0000;
    assign AWREGION   = 4'b0000;
    assign AWUSER     = '0;
    assign AWVALID    = (state == S_AW);

    assign WDATA      = wr_data;
    assign WSTRB      = '1;
    assign WLAST      = last_beat;
    assign WUSER      = '0;
    assign WVALID     = (state == S_W) && wr_valid;
    assign wr_ready   = (state == S_W) && WREADY;

    assign BREADY     = (state == S_B);

    assign ARID       = ID_WIDTH'(MASTER_ID);
    assign ARADDR     = addr_q;
    assign ARLEN      = len_q;
    assign ARSIZE     = 3'(SIZE);
    assign ARBURST    = 2'b01;
    assign ARLOCK     = 1'b0;
    assign ARCACHE    = 4'b0000;
    assign ARPROT     = 3'b000;
    assign ARQOS      = 4'b0000;
    assign ARREGION   = 4'b0000;
    assign ARUSER     = '0;
    assign ARVALID    = (state == S_AR);

    assign rd_data    = RDATA;
    assign rd_last    = (state == S_R) && RLAST;
    assign rd_valid   = (state == S_R) && RVALID;
    assign RREADY     = (state == S_R) && rd_ready;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state      <= S_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            write_q    <= 1'b0;
            beat       <= '0;
            err_sticky <= 1'b0;
            done       <= 1'b0;
            resp_err   <= 1'b0;
        end else begin
            done     <= 1'b0;
            resp_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        addr_q     <= cmd_addr & ~ADDR_WIDTH'(STRB_WIDTH - 1);
                        len_q      <= cmd_len;
                        write_q    <= cmd_write;
                        beat       <= '0;
                        err_sticky <= 1'b0;
                        state      <= S_CHK;
                    end
                end
                S_CHK: begin
                    if (cross_4k) begin
                        done     <= 1'b1;
                        resp_err <= 1'b1;
                        state    <= S_ERR;
                    end else begin
                        state <= write_q ? S_AW : S_AR;
                    end
                end
                S_ERR: state <= S_IDLE;
                S_AW: begin
                    if (AWREADY) state <= S_W;
                end
                S_W: begin
                    if (w_fire) begin
                        beat <= beat_inc;
                        if (last_beat) state <= S_B;
                    end
                end
                S_B: begin
                    if (BVALID) begin
                        done     <= 1'b1;
                        resp_err <= b_err;
                        state    <= S_IDLE;
                    end
                end
                S_AR: begin
                    if (ARREADY) state <= S_R;
                end
                S_R: begin
                    if (r_fire) begin
                        beat       <= beat_inc;
                        err_sticky <= err_sticky | r_beat_err;
                        if (RLAST) begin
                            done     <= 1'b1;
                            resp_err <= err_sticky | r_beat_err;
                            state    <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_burst_master.sv
// Randomized bench for axi_burst_master: a cycle-stepped slave/user model with a transaction-level
// memory reference predicting addresses, beat data, last flags, done timing and resp_err.
module tb_axi_burst_master;

    localparam int AW  = 32;
    localparam int DW  = 64;
    localparam int IW  = 4;
    localparam int UW  = 1;
    localparam int MID = 3;

    logic ACLK, ARESETn;
    logic cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [7:0] cmd_len;
    logic [DW-1:0] wr_data;
    logic wr_valid, wr_ready;
    logic [DW-1:0] rd_data;
    logic rd_last, rd_valid, rd_ready;
    logic done, resp_err;
    logic [IW-1:0] AWID, ARID, BID, RID;
    logic [AW-1:0] AWADDR, ARADDR;
    logic [7:0] AWLEN, ARLEN;
    logic [2:0] AWSIZE, ARSIZE, AWPROT, ARPROT;
    logic [1:0] AWBURST, ARBURST, BRESP, RRESP;
    logic AWLOCK, ARLOCK;
    logic [3:0] AWCACHE, ARCACHE, AWQOS, ARQOS, AWREGION, ARREGION;
    logic [UW-1:0] AWUSER, ARUSER, WUSER;
    logic AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
    logic ARVALID, ARREADY, RLAST, RVALID, RREADY;
    logic [DW-1:0] WDATA, RDATA;
    logic [DW/8-1:0] WSTRB;

    int checks = 0;
    int errors = 0;

    logic [63:0] slave_mem [int unsigned];
    logic [63:0] ref_mem   [int unsigned];

    axi_burst_master #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .USER_WIDTH(UW), .MASTER_ID(MID)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .done(done), .resp_err(resp_err),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWPROT(AWPROT), .AWQOS(AWQOS),
        .AWREGION(AWREGION), .AWUSER(AWUSER), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WUSER(WUSER),
        .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT), .ARQOS(ARQOS),
        .ARREGION(ARREGION), .ARUSER(ARUSER), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] init_word(input int unsigned w);
        return {w, ~w};
    endfunction

    function automatic logic [63:0] slave_rd(input int unsigned w);
        return slave_mem.exists(w) ? slave_mem[w] : init_word(w);
    endfunction

    function automatic logic [63:0] ref_rd(input int unsigned w);
        return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
    endfunction

    task automatic idle_inputs();
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
        wr_data = '0; wr_valid = 0; rd_ready = 0;
        AWREADY = 0; WREADY = 0; BID = '0; BRESP = '0; BVALID = 0; ARREADY = 0;
        RID = '0; RDATA = '0; RRESP = '0; RLAST = 0; RVALID = 0;
    endtask

    // early_last: beat index on which the slave raises RLAST (-1 = normal); rst_at: W beat at which
    // reset is pulled (-1 = none).
    task automatic run_cmd(input bit wr, input logic [31:0] addr, input int len, input bit stall,
                           input bit seq_data, input logic [1:0] err_resp, input int early_last,
                           input bit bad_id, input int rst_at);
        logic [63:0] wq[$];
        logic [31:0] base_a;
        int unsigned base_w;
        bit err4k, exp_err, exp_done, pend_done, saw_ax, b_pend, r_act, rv_keep, finished, was_rst;
        int it, widx, sidx, ridx, last_idx;
        base_a   = addr & ~32'h7;
        base_w   = base_a >> 3;
        err4k    = (int'(base_a[11:0]) + (len + 1) * 8) > 4096;
        last_idx = (early_last >= 0 && early_last < len) ? early_last : len;
        for (int i = 0; i <= len; i++) wq.push_back(seq_data ? 64'(i) : {$urandom, $urandom});
        exp_err  = err4k || (err_resp != 2'b00) || bad_id || (!wr && last_idx != len);

        @(negedge ACLK);
        cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_len = 8'(len);
        #1 check("cmd_ready_idle", 64'(cmd_ready), 64'(1));

        widx = 0; sidx = 0; ridx = 0; pend_done = 0; saw_ax = 0; b_pend = 0; r_act = 0;
        rv_keep = 0; finished = 0; was_rst = 0;
        for (it = 1; it < 400 && !finished; it++) begin
            @(negedge ACLK);
            cmd_valid = 0; cmd_addr = $urandom; cmd_len = 8'($urandom); cmd_write = 1'($urandom);
            wr_valid  = (widx <= len) && (!stall || ($urandom % 3 != 0));
            if (widx <= len) wr_data = wq[widx];
            else wr_data = {$urandom, $urandom};
            rd_ready  = !stall || !(it >= 5 && it < 8);
            AWREADY   = !stall || ($urandom % 2 == 1);
            ARREADY   = !stall || ($urandom % 2 == 1);
            WREADY    = !stall || (it % 2 == 1);
            BVALID    = b_pend;
            BID       = IW'(bad_id ? MID + 1 : MID);
            RID       = IW'(bad_id ? MID + 1 : MID);
            BRESP     = err_resp;
            RRESP     = err_resp;
            if (!rv_keep) RVALID = r_act && (!stall || ($urandom % 4 != 0));
            RDATA     = slave_rd(base_w + sidx);
            RLAST     = r_act && (sidx == last_idx);
            #1;
            exp_done = pend_done || (err4k && it == 2);
            if (done || exp_done) begin
                check("done", 64'(done), 64'(exp_done));
                check("resp_err", 64'(resp_err), 64'(exp_err));
                if (exp_done) finished = 1;
            end
            pend_done = 0;
            if ((AWVALID || ARVALID) && !saw_ax) begin
                saw_ax = 1;
                check("axvalid_latency", 64'(it), 64'(2));
            end
            if (rst_at >= 0 && WVALID && widx == rst_at) begin
                ARESETn = 0;
                #1;
                check("rst_wvalid", 64'(WVALID), 64'(0));
                check("rst_awvalid", 64'(AWVALID), 64'(0));
                check("rst_cmd_ready", 64'(cmd_ready), 64'(0));
                check("rst_done", 64'(done), 64'(0));
                finished = 1;
                was_rst = 1;
            end else begin
                if (AWVALID && AWREADY) begin
                    check("awaddr", 64'(AWADDR), 64'(base_a));
                    check("awlen", 64'(AWLEN), 64'(len));
                    check("awid", 64'(AWID), 64'(MID));
                    check("awsize_burst", {AWSIZE, AWBURST}, {3'd3, 2'b01});
                end
                if (WVALID && WREADY) begin
                    if (widx > len) begin
                        check("w_extra_beat", 64'(widx), 64'(len));
                    end else begin
                        check("wdata", WDATA, wq[widx]);
                        check("wlast", 64'(WLAST), 64'(widx == len));
                        check("wstrb", 64'(WSTRB), 64'hFF);
                        slave_mem[base_w + widx] = WDATA;
                        widx++;
                        if (widx == len + 1) b_pend = 1;
                    end
                end
                if (BVALID && BREADY) begin
                    b_pend = 0;
                    pend_done = 1;
                end
                if (ARVALID && ARREADY) begin
                    check("araddr", 64'(ARADDR), 64'(base_a));
                    check("arlen", 64'(ARLEN), 64'(len));
                    check("arid", 64'(ARID), 64'(MID));
                    r_act = 1;
                end
                if (rd_valid) begin
                    check("rd_data", rd_data, ref_rd(base_w + ridx));
                    check("rd_last", 64'(rd_last), 64'(ridx == last_idx));
                end
                if (RVALID && RREADY) begin
                    if (RLAST) begin
                        r_act = 0;
                        pend_done = 1;
                    end
                    sidx++;
                    ridx++;
                    rv_keep = 0;
                end else begin
                    rv_keep = RVALID;
                end
            end
        end
        if (!finished) check("timeout", 64'(it), 64'(0));
        check("ax_seen", 64'(saw_ax), 64'(!err4k));

        if (was_rst) begin
            for (int i = 0; i < rst_at; i++) ref_mem[base_w + i] = wq[i];
            @(negedge ACLK);
            idle_inputs();
            ARESETn = 1;
            #1 check("rst_release_cmd_ready", 64'(cmd_ready), 64'(1));
        end else begin
            if (!err4k && wr) begin
                check("w_beats", 64'(widx), 64'(len + 1));
                for (int i = 0; i <= len; i++) ref_mem[base_w + i] = wq[i];
            end
            if (!err4k && !wr) check("r_beats", 64'(ridx), 64'(last_idx + 1));
            @(negedge ACLK);
            idle_inputs();
            #1;
            check("done_pulse_end", 64'(done), 64'(0));
            check("ready_after_done", 64'(cmd_ready), 64'(1));
        end
    endtask

    initial begin
        ARESETn = 0;
        idle_inputs();
        repeat (3) @(negedge ACLK);
        #1;
        check("rst_cmd_ready", 64'(cmd_ready), 64'(0));
        check("rst_valids", {AWVALID, ARVALID, WVALID, BREADY, RREADY}, 64'(0));
        check("rst_done_err", {done, resp_err}, 64'(0));
        @(negedge ACLK);
        ARESETn = 1;
        #1 check("cmd_ready_after_rst", 64'(cmd_ready), 64'(1));

        run_cmd(1, 32'h0, 7, 0, 1, 2'b00, -1, 0, -1);
        run_cmd(0, 32'h0, 7, 0, 0, 2'b00, -1, 0, -1);
        run_cmd(1, 32'h8000_0000, 3, 1, 0, 2'b00, -1, 0, -1);
        run_cmd(0, 32'h8000_0000, 3, 1, 0, 2'b00, -1, 0, -1);
        run_cmd(1, 32'hFF8, 1, 0, 0, 2'b00, -1, 0, -1);
        run_cmd(0, 32'h1FF8, 0, 0, 0, 2'b00, -1, 0, -1);
        run_cmd(1, 32'h100, 2, 0, 0, 2'b10, -1, 0, -1);
        run_cmd(0, 32'h100, 3, 0, 0, 2'b00, 2, 0, -1);
        run_cmd(0, 32'h100, 2, 0, 0, 2'b00, -1, 1, -1);
        run_cmd(1, 32'h300, 7, 0, 0, 2'b00, -1, 0, 4);
        run_cmd(0, 32'h300, 7, 0, 0, 2'b00, -1, 0, -1);
        run_cmd(1, 32'h2000, 255, 0, 0, 2'b00, -1, 0, -1);
        run_cmd(0, 32'h2000, 255, 0, 0, 2'b00, -1, 0, -1);

        for (int n = 0; n < 30; n++) begin
            logic [31:0] a;
            int l;
            a = 32'h1000 * ($urandom % 3) + ($urandom % 4096);
            l = ($urandom % 4 == 0) ? int'($urandom % 48) : int'($urandom % 9);
            run_cmd(1'($urandom), a, l, 1'($urandom), 0,
                    ($urandom % 6 == 0) ? 2'b10 : 2'b00, -1, 0, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
